// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter that serialises read/write transactions
// onto a single-port RAM and returns read data on per-requester response pulses.
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t      state, next_state;
    logic        last_grant;   // 1 = requester 1 was granted most recently
    logic        grant_id;
    logic [1:0]  wait_cnt;
    logic        grant0, grant1, handshake;
    logic        sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        // NOTE: ready is gated by rst directly so no handshake can slip through while reset is held.
        req0_ready = ~rst & (state == IDLE) & grant0;
        req1_ready = ~rst & (state == IDLE) & grant1;
        handshake  = req0_ready | req1_ready;
        sel_we     = req1_ready ? req1_we    : req0_we;
        sel_addr   = req1_ready ? req1_addr  : req0_addr;
        sel_wdata  = req1_ready ? req1_wdata : req0_wdata;
        busy       = (state != IDLE);

        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = ISSUE;
            ISSUE:   next_state = ram_we ? IDLE : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // RAM port and response registers; ram_addr/ram_data_in only change on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            wait_cnt    <= '0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_rdata  <= '0;
            rsp1_rdata  <= '0;
        end else begin
            ram_we     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        grant_id    <= req1_ready;
                        last_grant  <= req1_ready;
                        ram_we      <= sel_we;
                        ram_addr    <= sel_addr;
                        ram_data_in <= sel_wdata;
                    end
                end
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_cnt == WAIT_LAST) begin
                        if (grant_id) begin
                            rsp1_rdata <= ram_data_out;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_rdata <= ram_data_out;
                            rsp0_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM models, a transaction
// scoreboard for read responses and directed reset/tie/fairness/latency steps.
module tb_ram_arbiter;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance (RD_LAT = 1)
    logic       req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
    logic [3:0] req0_addr = 0, req1_addr = 0;
    logic [7:0] req0_wdata = 0, req1_wdata = 0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_rdata, rsp1_rdata;
    logic       ram_we, busy;
    logic [3:0] ram_addr;
    logic [7:0] ram_data_in, ram_data_out;

    ram_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    logic [7:0] mem [16];
    logic [7:0] pipe;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        pipe <= mem[ram_addr];
    end
    assign ram_data_out = pipe;

    // Second instance (RD_LAT = 3)
    logic       r3_req0_valid = 0, r3_req0_we = 0, r3_req1_valid = 0, r3_req1_we = 0;
    logic [3:0] r3_req0_addr = 0, r3_req1_addr = 0;
    logic [7:0] r3_req0_wdata = 0, r3_req1_wdata = 0;
    logic       r3_req0_ready, r3_req1_ready, r3_rsp0_valid, r3_rsp1_valid;
    logic [7:0] r3_rsp0_rdata, r3_rsp1_rdata;
    logic       r3_ram_we, r3_busy;
    logic [3:0] r3_ram_addr;
    logic [7:0] r3_ram_data_in, r3_ram_data_out;

    ram_arbiter #(.ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(r3_req0_valid), .req0_we(r3_req0_we), .req0_addr(r3_req0_addr),
        .req0_wdata(r3_req0_wdata), .req0_ready(r3_req0_ready),
        .rsp0_valid(r3_rsp0_valid), .rsp0_rdata(r3_rsp0_rdata),
        .req1_valid(r3_req1_valid), .req1_we(r3_req1_we), .req1_addr(r3_req1_addr),
        .req1_wdata(r3_req1_wdata), .req1_ready(r3_req1_ready),
        .rsp1_valid(r3_rsp1_valid), .rsp1_rdata(r3_rsp1_rdata),
        .ram_we(r3_ram_we), .ram_addr(r3_ram_addr), .ram_data_in(r3_ram_data_in),
        .ram_data_out(r3_ram_data_out), .busy(r3_busy)
    );

    logic [7:0] mem3 [16];
    logic [7:0] pipe3 [3];
    always @(posedge clk) begin
        if (r3_ram_we) mem3[r3_ram_addr] <= r3_ram_data_in;
        pipe3[0] <= mem3[r3_ram_addr];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign r3_ram_data_out = pipe3[2];

    // Scoreboard state
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         we_due = -1;
    logic [3:0] we_addr;
    logic [7:0] we_data;
    logic [7:0] model [16];
    exp_t       q0[$], q1[$];
    txn_t       tq0[$], tq1[$];
    bit         glog[$];
    bit         last_hs0, last_hs1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic record(input bit id, input logic we, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        glog.push_back(id);
        if (we) begin
            model[addr] = data;
            we_due  = cyc + 1;
            we_addr = addr;
            we_data = data;
        end else begin
            e.data = model[addr];
            e.due  = cyc + 2 + LAT;
            if (id) q1.push_back(e);
            else    q0.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        last_hs0 = 0;
        last_hs1 = 0;
        if (rst) begin
            q0.delete();
            q1.delete();
            we_due = -1;
            return;
        end
        check("ram_we", ram_we, cyc == we_due);
        if (ram_we) begin
            check("ram_addr", ram_addr, we_addr);
            check("ram_data_in", ram_data_in, we_data);
        end
        if (rsp0_valid) begin
            if (q0.size() == 0) check("rsp0_spurious", rsp0_valid, 0);
            else begin
                e = q0.pop_front();
                check("rsp0_rdata", rsp0_rdata, e.data);
                check("rsp0_cycle", cyc, e.due);
            end
        end else if (q0.size() > 0 && cyc > q0[0].due) begin
            check("rsp0_missing", cyc, q0[0].due);
            void'(q0.pop_front());
        end
        if (rsp1_valid) begin
            if (q1.size() == 0) check("rsp1_spurious", rsp1_valid, 0);
            else begin
                e = q1.pop_front();
                check("rsp1_rdata", rsp1_rdata, e.data);
                check("rsp1_cycle", cyc, e.due);
            end
        end else if (q1.size() > 0 && cyc > q1[0].due) begin
            check("rsp1_missing", cyc, q1[0].due);
            void'(q1.pop_front());
        end
        last_hs0 = req0_valid & req0_ready;
        last_hs1 = req1_valid & req1_ready;
        if (last_hs0) record(0, req0_we, req0_addr, req0_wdata);
        if (last_hs1) record(1, req1_we, req1_addr, req1_wdata);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic apply();
        req0_valid = (tq0.size() > 0);
        if (tq0.size() > 0) begin
            req0_we = tq0[0].we; req0_addr = tq0[0].addr; req0_wdata = tq0[0].data;
        end
        req1_valid = (tq1.size() > 0);
        if (tq1.size() > 0) begin
            req1_we = tq1[0].we; req1_addr = tq1[0].addr; req1_wdata = tq1[0].data;
        end
    endtask

    task automatic run();
        int n = 0;
        apply();
        while ((tq0.size() > 0 || tq1.size() > 0) && n < 200) begin
            step();
            if (last_hs0) void'(tq0.pop_front());
            if (last_hs1) void'(tq1.pop_front());
            apply();
            n++;
        end
        check("queue_drained", tq0.size() + tq1.size(), 0);
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 20) begin
            step();
            n++;
        end
        check("rsp_drained", q0.size() + q1.size(), 0);
        step();
    endtask

    function automatic txn_t t(input logic we, input logic [3:0] addr, input logic [7:0] data);
        txn_t x;
        x.we = we; x.addr = addr; x.data = data;
        return x;
    endfunction

    initial begin
        // Power-on reset state
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data_in", ram_data_in, 0);
        check("rst_rsp0", {rsp0_valid, rsp0_rdata}, 0);
        check("rst_rsp1", {rsp1_valid, rsp1_rdata}, 0);
        rst = 0;
        step();

        // Reset in the WAIT of a req0 read of addr 1
        tq0.push_back(t(0, 4'd1, 8'h00));
        apply();
        step();
        void'(tq0.pop_front());
        apply();
        step();
        check("t1_busy_wait", busy, 1);
        check("t1_addr_wait", ram_addr, 1);
        req0_valid = 1;
        rst = 1;
        #1;
        check("t1_busy", busy, 0);
        check("t1_ram_addr", ram_addr, 0);
        check("t1_ram_we", ram_we, 0);
        check("t1_ready0", req0_ready, 0);
        check("t1_rsp0", {rsp0_valid, rsp0_rdata}, 0);
        step(); step();
        req0_valid = 0;
        rst = 0;
        for (int i = 0; i < 6; i++) step();

        // Single requester write then read
        tq0.push_back(t(1, 4'd1, 8'hAA));
        tq0.push_back(t(0, 4'd1, 8'h00));
        run();
        check("t2_rdata", rsp0_rdata, 8'hAA);

        // Tie from reset
        rst = 1;
        step();
        tq0.push_back(t(1, 4'd3, 8'h11));
        tq1.push_back(t(1, 4'd3, 8'h22));
        apply();
        #1;
        check("t3_ready_in_rst", {req0_ready, req1_ready}, 0);
        step();
        rst = 0;
        glog.delete();
        run();
        check("t3_grants", glog.size(), 2);
        if (glog.size() >= 2) begin
            check("t3_first", glog[0], 0);
            check("t3_second", glog[1], 1);
        end
        tq0.push_back(t(0, 4'd3, 8'h00));
        run();
        check("t3_rdata", rsp0_rdata, 8'h22);

        // Fairness under continuous contention
        for (int i = 0; i < 6; i++) tq1.push_back(t(1, 4'(i), 8'(8'h30 + i)));
        run();
        glog.delete();
        for (int i = 0; i < 6; i++) begin
            tq0.push_back(t(0, 4'(i), 8'h00));
            tq1.push_back(t(0, 4'(i), 8'h00));
        end
        run();
        check("t4_grants", glog.size(), 12);
        if (glog.size() > 0) check("t4_first", glog[0], 0);
        for (int i = 1; i < glog.size(); i++) check("t4_alternate", glog[i], !glog[i-1]);

        // Address boundaries
        tq0.push_back(t(1, 4'd15, 8'hFF));
        tq0.push_back(t(1, 4'd0, 8'h00));
        tq0.push_back(t(0, 4'd15, 8'h00));
        run();
        check("t5_rdata15", rsp0_rdata, 8'hFF);
        tq1.push_back(t(0, 4'd0, 8'h00));
        run();
        check("t5_rdata0", rsp1_rdata, 8'h00);

        // RD_LAT = 3 instance: preload addr 7, then req1 read
        r3_req0_valid = 1; r3_req0_we = 1; r3_req0_addr = 4'd7; r3_req0_wdata = 8'h5C;
        #1;
        check("t6_wr_ready", r3_req0_ready, 1);
        step();
        r3_req0_valid = 0;
        check("t6_wr_we", r3_ram_we, 1);
        step(); step();
        r3_req1_valid = 1; r3_req1_we = 0; r3_req1_addr = 4'd7;
        #1;
        check("t6_rd_ready", r3_req1_ready, 1);
        step();
        r3_req1_valid = 0;
        for (int n = 1; n <= 5; n++) begin
            check($sformatf("t6_rsp1_valid_c%0d", n), r3_rsp1_valid, n == 5);
            if (n >= 2 && n <= 4) begin
                check($sformatf("t6_addr_c%0d", n), r3_ram_addr, 4'd7);
                check($sformatf("t6_we_c%0d", n), r3_ram_we, 0);
            end
            if (n < 5) step();
        end
        check("t6_rdata", r3_rsp1_rdata, 8'h5C);
        check("t6_rsp0_quiet", r3_rsp0_valid, 0);
        step();
        check("t6_rsp1_pulse", r3_rsp1_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
